// File: rtl/fu_ls_agu_queue_if.sv
// Issue-side and LSQ-side handshake bundle for the load/store AGU queue.
interface fu_ls_agu_queue_if #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int LSQ_IDX_LEN = 3,
  parameter int TAG_LEN     = 6,
  parameter int CNT_W       = $clog2(DEPTH+1)
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_is_store;
  logic [XLEN-1:0]        in_base;
  logic [XLEN-1:0]        in_imm;
  logic [XLEN-1:0]        in_store_data;
  logic [2:0]             in_mem_size;
  logic [LSQ_IDX_LEN-1:0] in_lq_pos;
  logic [LSQ_IDX_LEN-1:0] in_sq_pos;
  logic [TAG_LEN-1:0]     in_dest_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_is_store;
  logic [XLEN-1:0]        out_addr;
  logic [XLEN-1:0]        out_store_data;
  logic [2:0]             out_mem_size;
  logic [LSQ_IDX_LEN-1:0] out_lq_pos;
  logic [LSQ_IDX_LEN-1:0] out_sq_pos;
  logic [TAG_LEN-1:0]     out_dest_tag;
  logic                   out_misaligned;
  logic [CNT_W-1:0]       count;

  modport master (
    output in_valid, in_is_store, in_base, in_imm, in_store_data, in_mem_size,
           in_lq_pos, in_sq_pos, in_dest_tag, out_ready,
    input  in_ready, out_valid, out_is_store, out_addr, out_store_data, out_mem_size,
           out_lq_pos, out_sq_pos, out_dest_tag, out_misaligned, count
  );
  modport slave (
    input  in_valid, in_is_store, in_base, in_imm, in_store_data, in_mem_size,
           in_lq_pos, in_sq_pos, in_dest_tag, out_ready,
    output in_ready, out_valid, out_is_store, out_addr, out_store_data, out_mem_size,
           out_lq_pos, out_sq_pos, out_dest_tag, out_misaligned, count
  );
endinterface

// File: rtl/fu_ls_agu_queue.sv
// Load/store AGU with an in-order DEPTH-entry result buffer feeding the LSQ.
// Define FU_LS_AGU_BYPASS_EN for zero-latency pass-through when the buffer is empty.
module fu_ls_agu_queue #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int LSQ_IDX_LEN = 3,
  parameter int TAG_LEN     = 6,
  parameter int CNT_W       = $clog2(DEPTH+1)
) (
  input  logic clock,
  input  logic reset,
  input  logic squash,
  fu_ls_agu_queue_if.slave io
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic                   is_store;
    logic [XLEN-1:0]        addr;
    logic [XLEN-1:0]        store_data;
    logic [2:0]             mem_size;
    logic [LSQ_IDX_LEN-1:0] lq_pos;
    logic [LSQ_IDX_LEN-1:0] sq_pos;
    logic [TAG_LEN-1:0]     dest_tag;
    logic                   misaligned;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_ent, out_ent;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt;
  logic             empty, push, pop, bypass;

  function automatic logic misalign(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Non-power-of-2 depth: wrap by explicit compare.
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ent            = '0;
    in_ent.is_store   = io.in_is_store;
    in_ent.addr       = io.in_base + io.in_imm;
    in_ent.store_data = io.in_store_data;
    in_ent.mem_size   = io.in_mem_size;
    in_ent.lq_pos     = io.in_lq_pos;
    in_ent.sq_pos     = io.in_sq_pos;
    in_ent.dest_tag   = io.in_dest_tag;
    in_ent.misaligned = misalign(io.in_mem_size[1:0], in_ent.addr[1:0]);
  end

  assign empty = (cnt == '0);
`ifdef FU_LS_AGU_BYPASS_EN
  assign bypass = empty && io.in_valid && io.out_ready && !squash && !reset;
`else
  assign bypass = 1'b0;
`endif
  assign io.in_ready = !reset && (cnt < CNT_W'(DEPTH));
  assign push        = io.in_valid && io.in_ready && !squash && !bypass;
  assign pop         = !empty && io.out_ready;
  assign io.out_valid = !empty || bypass;
  // Zero the head view when empty so stale post-squash data never leaks out.
  assign out_ent     = bypass ? in_ent : (empty ? '0 : mem[head]);

  assign io.out_is_store   = out_ent.is_store;
  assign io.out_addr       = out_ent.addr;
  assign io.out_store_data = out_ent.store_data;
  assign io.out_mem_size   = out_ent.mem_size;
  assign io.out_lq_pos     = out_ent.lq_pos;
  assign io.out_sq_pos     = out_ent.sq_pos;
  assign io.out_dest_tag   = out_ent.dest_tag;
  assign io.out_misaligned = out_ent.misaligned;
  assign io.count          = cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (squash) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_ent;
        tail      <= inc(tail);
      end
      if (pop) head <= inc(head);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: doc/fu_ls_agu_queue.md
Name: fu_ls_agu_queue

Overview:
- Parametrised load/store address-generation unit with a DEPTH-entry in-order result buffer.
- Sits between the RS issue port and the LSQ.
- Per accepted op: computes the effective address base+imm, checks alignment, queues the result with its LQ/SQ position and destination tag.
- Drains to the LSQ over a valid/ready handshake, so issue is not blocked while the LSQ stalls (up to DEPTH ops).

Parameters:
XLEN, 32, datapath/address width
DEPTH, 4, result buffer entries (>=2, need not be a power of 2)
LSQ_IDX_LEN, 3, width of load/store queue position fields
TAG_LEN, 6, width of destination physical-register tag
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
squash  in  1  flush all buffered ops (branch mispredict)
in_valid  in  1  issue slot carries a load/store with ready operands
in_ready  out  1  unit can accept this cycle
in_is_store  in  1  1=store, 0=load
in_base  in  XLEN  rs1 value
in_imm  in  XLEN  immediate, already sign-extended (I-imm for loads, S-imm for stores)
in_store_data  in  XLEN  rs2 value (don't-care for loads)
in_mem_size  in  3  funct3 (bits[1:0] size, bit[2] unsigned)
in_lq_pos  in  LSQ_IDX_LEN  load queue slot
in_sq_pos  in  LSQ_IDX_LEN  store queue slot
in_dest_tag  in  TAG_LEN  destination tag (loads)
out_valid  out  1  head entry valid
out_ready  in  1  LSQ accepts head this cycle
out_is_store  out  1  head type
out_addr  out  XLEN  head effective address
out_store_data  out  XLEN  head store data
out_mem_size  out  3  head funct3
out_lq_pos  out  LSQ_IDX_LEN  head LQ slot
out_sq_pos  out  LSQ_IDX_LEN  head SQ slot
out_dest_tag  out  TAG_LEN  head tag
out_misaligned  out  1  head address misaligned for its size
count  out  CNT_W  occupied entries

Behaviour:
- Reset: single clock; reset is synchronous and active-high, sampled on posedge clock.
  - Reset clears head, tail and count to 0 and every stored entry to 0.
  - All out_* are 0 while empty.
  - in_ready is forced 0 while reset is high.
- Push: occurs when in_valid && in_ready && !squash && !reset.
  - in_ready = (count < DEPTH), combinational from registered count only; it does not look at out_ready.
  - A full buffer refuses a push even when a pop happens the same cycle.
- Address: out_addr = in_base + in_imm, truncated to XLEN (wraps mod 2^XLEN, no overflow flag). It is computed at push and stored, so no arithmetic sits on the output path.
- Misalignment, computed at push from in_mem_size[1:0]:
  - 00 (byte): never misaligned.
  - 01 (half): addr[0].
  - 10 (word): addr[1:0] != 0.
  - 11: always 1 (unsupported size).
  - in_mem_size[2] is ignored for this check.
- Pop: occurs when out_valid && out_ready. out_valid = (count != 0). All out_* show the head entry combinationally from storage.
- Latency: an op pushed in cycle N is visible at the outputs in cycle N+1 at the earliest. Order is strict FIFO.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 (explicit compare, no power-of-2 masking).
- Squash: highest priority after reset.
  - Next cycle, count=0 and pointers=0.
  - A push or pop presented in the squash cycle has no effect.
  - Stored data need not be cleared, but out_valid must be 0.
- Output stability: while out_valid && !out_ready, head fields are held stable.

Optional Feature:
- FU_LS_AGU_BYPASS_EN defined:
  - When count==0 and in_valid && out_ready && !squash, the input op drives out_* combinationally (address/misaligned from a duplicate adder/checker).
  - It is consumed that cycle with zero latency and not written to the buffer. out_valid = in_valid in that case.
  - When count==0 and out_ready is low, the op is pushed normally.
- Undefined: no bypass; minimum latency is 1 cycle as above.

Test Plan:
- Reset, then load base=0x1000 imm=0xFFFFFFFC size=010 lq=2 tag=5 with out_ready=1 -> next cycle out_valid=1, out_addr=0x00000FFC, out_misaligned=0, out_lq_pos=2, out_dest_tag=5; following cycle count=0.
- out_ready=0, push 5 ops at DEPTH=4 -> in_ready drops after the 4th (count=4); 5th held. Raise out_ready -> outputs in push order; 5th accepted the cycle after the first pop; pointers wrap 3->0.
- Full buffer, in_valid=1 and out_ready=1 same cycle -> pop occurs, push refused, count 4->3.
- Store half base=0x2001 imm=0 data=0xABCD size=001 -> out_misaligned=1, out_is_store=1, out_store_data=0xABCD. Word at 0x2002 -> misaligned=1. Byte at 0x2003 -> 0. size=011 -> 1.
- 3 entries buffered, assert squash with in_valid=1 -> next cycle count=0, out_valid=0, squashed-cycle input not present.
- With FU_LS_AGU_BYPASS_EN, empty buffer, out_ready=1, load base=8 imm=4 -> out_valid=1 and out_addr=0xC in the same cycle; count stays 0.
